// File: rtl/snn_ctrl_pkg.sv
// Shared encodings and default widths for the SNN sweep controller
// and the IF neuron core.
package snn_ctrl_pkg;

    localparam int DEF_N_POST         = 256;
    localparam int DEF_POST_ADDR_W    = 8;
    localparam int DEF_PRE_ADDR_W     = 8;
    localparam int DEF_OUT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        CMD_SYN   = 2'd0,
        CMD_TSTEP = 2'd1,
        CMD_TREF  = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/spike_aer_fifo.sv
// Synchronous first-word fall-through FIFO for AER addresses,
// with occupancy output; pointers wrap modulo DEPTH (power of 2).
module spike_aer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Next pointer/occupancy; pop on empty and push on full are dropped
    always_comb begin
        do_push  = push && (count_q != (PW+1)'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/neuron_sweep_ctrl.sv
// Command sequencer feeding the IF neuron datapath: sweeps all
// post-neurons per command and queues time-step spikes as AER.
module neuron_sweep_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int N_POST          = DEF_N_POST,
    parameter int POST_ADDR_WIDTH = DEF_POST_ADDR_W,
    parameter int PRE_ADDR_WIDTH  = DEF_PRE_ADDR_W,
    parameter int OUT_FIFO_DEPTH  = DEF_OUT_FIFO_DEPTH
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     cmd_valid,
    input  logic [1:0]                               cmd_type,
    input  logic [PRE_ADDR_WIDTH-1:0]                cmd_addr,
    output logic                                     cmd_ready,
    output logic                                     state_rd_en,
    output logic [POST_ADDR_WIDTH-1:0]               state_rd_addr,
    output logic                                     state_wr_en,
    output logic [POST_ADDR_WIDTH-1:0]               state_wr_addr,
    output logic                                     weight_rd_en,
    output logic [PRE_ADDR_WIDTH+POST_ADDR_WIDTH-1:0] weight_rd_addr,
    output logic                                     neuron_event,
    output logic                                     time_step_event,
    output logic                                     time_ref_event,
    input  logic                                     spike_in,
    output logic                                     spk_valid,
    output logic [POST_ADDR_WIDTH-1:0]               spk_addr,
    input  logic                                     spk_ready,
    output logic                                     busy
);

    localparam int KW  = POST_ADDR_WIDTH + 1;
    localparam int FPW = $clog2(OUT_FIFO_DEPTH);
    localparam int GW  = FPW + 2;

    sweep_state_e                state_q, state_d;
    cmd_type_e                   type_q, type_d;
    logic [PRE_ADDR_WIDTH-1:0]   pre_q, pre_d;
    logic [KW-1:0]               k_q, k_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [POST_ADDR_WIDTH-1:0]  s1_idx_q, s1_idx_d;
    logic                        rst_q;

    logic                        accept, stall, issue, last;
    logic                        spk_push, fifo_empty;
    logic [FPW:0]                fifo_count;

    // Issue gating, index advance and FSM next state
    always_comb begin
        accept = cmd_valid && cmd_ready;
        stall  = (type_q == CMD_TSTEP) &&
                 ((GW'(fifo_count) + GW'(s1_valid_q)) >=
                  GW'(OUT_FIFO_DEPTH));
        issue  = (state_q == ST_SWEEP) && !stall;
        last   = (k_q == KW'(N_POST - 1));

        state_d    = state_q;
        type_d     = type_q;
        pre_d      = pre_q;
        k_d        = k_q;
        s1_valid_d = issue;
        s1_idx_d   = k_q[POST_ADDR_WIDTH-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    type_d  = cmd_type_e'(cmd_type);
                    pre_d   = cmd_addr;
                    k_d     = '0;
                    state_d = (cmd_type == CMD_RSVD) ? ST_DRAIN
                                                     : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (issue) begin
                    k_d = k_q + KW'(1);
                    if (last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM and pipeline registers; reset aborts any sweep in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            type_q     <= CMD_SYN;
            pre_q      <= '0;
            k_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            rst_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            pre_q      <= pre_d;
            k_q        <= k_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            rst_q      <= 1'b0;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE) && !rst_q;
    assign busy            = (state_q != ST_IDLE);

    assign state_rd_en     = issue;
    assign state_rd_addr   = k_q[POST_ADDR_WIDTH-1:0];
    assign weight_rd_en    = issue && (type_q == CMD_SYN);
    assign weight_rd_addr  = {pre_q, k_q[POST_ADDR_WIDTH-1:0]};

    assign state_wr_en     = s1_valid_q;
    assign state_wr_addr   = s1_idx_q;
    assign neuron_event    = s1_valid_q && (type_q == CMD_SYN);
    assign time_step_event = s1_valid_q && (type_q == CMD_TSTEP);
    assign time_ref_event  = s1_valid_q && (type_q == CMD_TREF);

    assign spk_push        = s1_valid_q && (type_q == CMD_TSTEP) &&
                             spike_in;

    spike_aer_fifo #(
        .WIDTH (POST_ADDR_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_spk_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (spk_push),
        .push_data (s1_idx_q),
        .pop       (spk_ready),
        .head_data (spk_addr),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign spk_valid = !fifo_empty;

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Scoreboard bench for neuron_sweep_ctrl: 8 neurons, 4-deep spike
// FIFO so the overflow stall and full index range are exercised.
module tb_neuron_sweep_ctrl;

    localparam int NP  = 8;
    localparam int PAW = 3;
    localparam int PRW = 8;
    localparam int FD  = 4;
    localparam int LAT = NP + 2;

    typedef struct packed {
        logic            w;
        logic [PRW+PAW-1:0] wa;
        logic [PAW-1:0]  a;
    } rd_t;

    logic               CLK = 1'b0;
    logic               RST;
    logic               cmd_valid;
    logic [1:0]         cmd_type;
    logic [PRW-1:0]     cmd_addr;
    logic               cmd_ready;
    logic               state_rd_en;
    logic [PAW-1:0]     state_rd_addr;
    logic               state_wr_en;
    logic [PAW-1:0]     state_wr_addr;
    logic               weight_rd_en;
    logic [PRW+PAW-1:0] weight_rd_addr;
    logic               neuron_event;
    logic               time_step_event;
    logic               time_ref_event;
    logic               spike_in;
    logic               spk_valid;
    logic [PAW-1:0]     spk_addr;
    logic               spk_ready;
    logic               busy;

    logic [NP-1:0]      mask;
    int                 tests = 0;
    int                 fails = 0;
    int                 wr_seen = 0;

    rd_t                exp_rd[$];
    logic [4:0]         exp_wr[$];
    logic [PAW-1:0]     exp_spk[$];

    always #5 CLK = ~CLK;

    assign spike_in = mask[state_wr_addr];

    neuron_sweep_ctrl #(
        .N_POST          (NP),
        .POST_ADDR_WIDTH (PAW),
        .PRE_ADDR_WIDTH  (PRW),
        .OUT_FIFO_DEPTH  (FD)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .cmd_valid       (cmd_valid),
        .cmd_type        (cmd_type),
        .cmd_addr        (cmd_addr),
        .cmd_ready       (cmd_ready),
        .state_rd_en     (state_rd_en),
        .state_rd_addr   (state_rd_addr),
        .state_wr_en     (state_wr_en),
        .state_wr_addr   (state_wr_addr),
        .weight_rd_en    (weight_rd_en),
        .weight_rd_addr  (weight_rd_addr),
        .neuron_event    (neuron_event),
        .time_step_event (time_step_event),
        .time_ref_event  (time_ref_event),
        .spike_in        (spike_in),
        .spk_valid       (spk_valid),
        .spk_addr        (spk_addr),
        .spk_ready       (spk_ready),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sweep(input logic [1:0] t,
                              input logic [PRW-1:0] pre);
        rd_t r;
        for (int k = 0; k < NP; k++) begin
            r.a  = PAW'(k);
            r.w  = (t == 2'd0);
            r.wa = {pre, PAW'(k)};
            exp_rd.push_back(r);
            exp_wr.push_back({t, PAW'(k)});
        end
    endtask

    // Read monitor
    always @(negedge CLK) begin
        rd_t e;
        logic [PRW+PAW:0] act, req;
        if (state_rd_en || weight_rd_en) begin
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected", {28'd0, state_rd_addr}, 32'hffff);
            end else begin
                e   = exp_rd.pop_front();
                act = {weight_rd_en,
                       weight_rd_en ? weight_rd_addr : '0};
                req = {e.w, e.w ? e.wa : '0};
                chk("rd_addr", {31'd0, state_rd_en, 28'd0,
                                state_rd_addr},
                    {31'd1, 28'd0, e.a});
                chk("rd_weight", 32'(act), 32'(req));
            end
        end
    end

    // Write-back / event monitor
    always @(negedge CLK) begin
        logic [2:0] ev;
        logic [1:0] code;
        logic [4:0] e;
        ev = {time_ref_event, time_step_event, neuron_event};
        if (state_wr_en || ev != 3'b000) begin
            unique case (ev)
                3'b001:  code = 2'd0;
                3'b010:  code = 2'd1;
                3'b100:  code = 2'd2;
                default: code = 2'd3;
            endcase
            if (!state_wr_en) code = 2'd3;
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {27'd0, code, state_wr_addr},
                    32'hffff);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_event", {27'd0, code, state_wr_addr},
                    {27'd0, e});
            end
            wr_seen++;
        end
    end

    // Spike AER monitor
    always @(negedge CLK) begin
        logic [PAW-1:0] e;
        if (spk_valid && spk_ready) begin
            if (exp_spk.size() == 0) begin
                chk("spk_unexpected", {29'd0, spk_addr}, 32'hffff);
            end else begin
                e = exp_spk.pop_front();
                chk("spk_addr", {29'd0, spk_addr}, {29'd0, e});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_spk_empty();
        int n = 0;
        while (spk_valid && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("spk_drained", {31'd0, spk_valid}, 0);
    endtask

    task automatic issue_cmd(input logic [1:0] t,
                             input logic [PRW-1:0] a);
        @(negedge CLK);
        wait_ready("issue");
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_addr  = a;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 1;
        @(negedge CLK);
        chk("ready_drop", {31'd0, cmd_ready}, 0);
        chk("busy_set", {31'd0, busy}, 1);
        while (!cmd_ready && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("busy_clear", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n;
        RST = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0;
        cmd_addr = '0; spk_ready = 1'b0; mask = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_outs", {26'd0, cmd_ready, busy, spk_valid,
                         state_rd_en, state_wr_en, weight_rd_en}, 0);
        @(negedge CLK);
        chk("rst_ready", {31'd0, cmd_ready}, 1);

        // SYN, spike_in high must not push
        mask = '1;
        push_sweep(2'd0, 8'd3);
        issue_cmd(2'd0, 8'd3);
        wait_done(LAT);
        chk("syn_no_spk", {31'd0, spk_valid}, 0);

        // TSTEP with spikes at 2 and 5
        mask = 8'b0010_0100;
        exp_spk.push_back(3'd2);
        exp_spk.push_back(3'd5);
        push_sweep(2'd1, 8'd0);
        issue_cmd(2'd1, 8'd0);
        wait_done(LAT);
        chk("tstep_spk_valid", {31'd0, spk_valid}, 1);
        chk("tstep_head", {29'd0, spk_addr}, 2);
        @(posedge CLK); #1 spk_ready = 1'b1;
        wait_spk_empty();
        @(posedge CLK); #1 spk_ready = 1'b0;
        chk("tstep_spk_left", exp_spk.size(), 0);

        // TSTEP overflow stall: all spike, FIFO of 4
        mask = '1;
        for (int k = 0; k < NP; k++) exp_spk.push_back(PAW'(k));
        push_sweep(2'd1, 8'd0);
        issue_cmd(2'd1, 8'd0);
        w0 = wr_seen;
        repeat (20) @(negedge CLK);
        chk("stall_writes", wr_seen - w0, FD);
        chk("stall_busy", {31'd0, busy}, 1);
        chk("stall_no_rd", {31'd0, state_rd_en}, 0);
        @(posedge CLK); #1 spk_ready = 1'b1;
        wait_ready("stall");
        wait_spk_empty();
        @(posedge CLK); #1 spk_ready = 1'b0;
        chk("stall_spk_left", exp_spk.size(), 0);

        // TREF, no weight reads
        mask = '1;
        push_sweep(2'd2, 8'd0);
        issue_cmd(2'd2, 8'd0);
        wait_done(LAT);
        chk("tref_no_spk", {31'd0, spk_valid}, 0);

        // Reset on cycle 3 of a TSTEP sweep with one queued spike
        mask = 8'b0000_0001;
        push_sweep(2'd1, 8'd0);
        issue_cmd(2'd1, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_rst_spk", {31'd0, spk_valid}, 1);
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_outs", {24'd0, state_rd_en, state_wr_en,
                           weight_rd_en, neuron_event,
                           time_step_event, time_ref_event,
                           spk_valid, busy}, 0);
        chk("abort_ready0", {31'd0, cmd_ready}, 0);
        #1;
        exp_rd.delete();
        exp_wr.delete();
        exp_spk.delete();
        @(negedge CLK);
        chk("abort_ready1", {31'd0, cmd_ready}, 1);
        push_sweep(2'd0, 8'd5);
        issue_cmd(2'd0, 8'd5);
        wait_done(LAT);

        // Back-to-back: TSTEP held valid through a SYN sweep
        mask = '0;
        push_sweep(2'd0, 8'd1);
        push_sweep(2'd1, 8'd0);
        @(negedge CLK);
        wait_ready("b2b");
        cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 8'd1;
        @(posedge CLK);
        #1 cmd_type = 2'd1; cmd_addr = 8'd0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!cmd_ready && n < 500);
        chk("b2b_latency", n, LAT);
        @(posedge CLK); #1 cmd_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_accepted", {30'd0, busy, cmd_ready}, 2);
        wait_ready("b2b_done");

        // Reserved type: one busy cycle, no SRAM activity
        issue_cmd(2'd3, 8'd7);
        wait_done(2);

        repeat (3) @(negedge CLK);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("spk_left", exp_spk.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_sweep_ctrl.md
Name: neuron_sweep_ctrl

Overview:
Sequencer directly upstream of the IF neuron datapath.
- Accepts commands: synaptic event for one pre-neuron, time-step, time-reference.
- For each command, sweeps all post-neurons. Per neuron it issues state/weight SRAM reads, strobes the matching neuron event aligned with read data, and writes back the next state.
- Spikes produced during a time-step sweep are queued as AER post-neuron addresses in an output FIFO for the next layer.

Parameters:
- N_POST, 256, number of post-synaptic neurons swept per command.
- POST_ADDR_WIDTH, 8, width of post-neuron index; N_POST <= 2^POST_ADDR_WIDTH.
- PRE_ADDR_WIDTH, 8, width of pre-neuron address carried by a synaptic command.
- OUT_FIFO_DEPTH, 16, spike AER FIFO depth; power of 2, >= 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset (see Behaviour).
- cmd_valid  in  1  command valid.
- cmd_type  in  2  0=SYN, 1=TSTEP, 2=TREF, 3=reserved (accepted, ignored, no sweep).
- cmd_addr  in  PRE_ADDR_WIDTH  pre-neuron address; used for SYN only.
- cmd_ready  out  1  high only in IDLE.
- state_rd_en  out  1  state/spike-count SRAM read enable.
- state_rd_addr  out  POST_ADDR_WIDTH  read index.
- state_wr_en  out  1  write-back enable.
- state_wr_addr  out  POST_ADDR_WIDTH  write index.
- weight_rd_en  out  1  weight SRAM read enable; SYN sweeps only.
- weight_rd_addr  out  PRE_ADDR_WIDTH+POST_ADDR_WIDTH  {pre_addr, post_idx}.
- neuron_event  out  1  to neuron datapath.
- time_step_event  out  1  to neuron datapath.
- time_ref_event  out  1  to neuron datapath.
- spike_in  in  1  neuron spike_out, sampled in the write-back cycle.
- spk_valid  out  1  spike FIFO non-empty.
- spk_addr  out  POST_ADDR_WIDTH  head post-neuron address.
- spk_ready  in  1  downstream pop.
- busy  out  1  sweep in progress (not IDLE).

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- On RST:
  - FSM goes to IDLE; FIFO is emptied.
  - All enables and event strobes are 0. cmd_ready, spk_valid and busy are 0 in the reset cycle; cmd_ready=1 from the next cycle.
  - Reset mid-sweep aborts the sweep with no further writes. SRAM contents are untouched.
- Handshake: a command is accepted when cmd_valid & cmd_ready. cmd_type and cmd_addr are latched.
- States: IDLE -> SWEEP -> DRAIN -> IDLE.
- Both SRAMs are 1R1W with 1-cycle read latency; the pipeline has 2 stages.
- Stage 0 (issue), in SWEEP:
  - Assert rd_en with index k (0..N_POST-1).
  - weight_rd_en only for SYN.
  - k increments on each issue.
  - After issuing k=N_POST-1, go to DRAIN.
- Stage 1 (complete), the cycle after an issue:
  - Exactly one event strobe matches the latched type: neuron_event / time_step_event / time_ref_event.
  - state_wr_en=1 with state_wr_addr = issued k.
  - Read of k+1 overlaps write of k, so one neuron completes per cycle.
- DRAIN: completes the last index, then returns to IDLE.
  - Unstalled sweep: accept at cycle 0; first issue at cycle 1; last write at cycle N_POST+1; cmd_ready=1 at cycle N_POST+2.
- Spike capture:
  - In a TSTEP stage-1 cycle with spike_in=1, push index k into the FIFO.
  - spike_in is ignored for SYN and TREF.
- Overflow guard: in TSTEP, stage 0 issues only if (fifo_count + stage1_valid) < OUT_FIFO_DEPTH.
  - Otherwise the issue stalls: no rd_en, k is held.
  - So a push never meets a full FIFO and no spike is lost.
  - SYN and TREF never stall.
- FIFO:
  - First-word fall-through; spk_valid = count != 0.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo OUT_FIFO_DEPTH.
- busy = (state != IDLE).
- Reserved type: accepted, returns to IDLE next cycle with no SRAM activity.
- Index counter width is POST_ADDR_WIDTH+1 so terminal detection works when N_POST = 2^POST_ADDR_WIDTH.

Decomposition:
- Shared package snn_ctrl_pkg:
  - cmd_type encodings: CMD_SYN=2'd0, CMD_TSTEP=2'd1, CMD_TREF=2'd2.
  - FSM state encodings.
  - Default widths shared with the neuron core.
- One natural sub-module: spike_aer_fifo (sync FIFO with count output, parameterised width and depth), reusable for other AER queues.

Test Plan:
- SYN, N_POST=4, cmd_addr=3: cmd_ready drops after accept. Weight addrs are {3,0}..{3,3} on cycles 1-4; neuron_event and state_wr_en on cycles 2-5 with wr_addr 0-3; cmd_ready=1 on cycle 6. No FIFO push even with spike_in=1.
- TSTEP, N_POST=8, spike_in=1 at indices 2 and 5, spk_ready=0: FIFO holds 2 then 5 in order; spk_valid=1; 8 time_step_event pulses.
- TSTEP, N_POST=32, OUT_FIFO_DEPTH=4, spike_in always 1, spk_ready=0 until cycle 20: issue stalls after 4 spikes. After pops resume, all 32 addresses 0..31 emerge in order; none dropped or duplicated.
- TREF: 256 time_ref_event pulses with wr_addr 0..255 consecutive; no weight reads.
- RST asserted on cycle 3 of a TSTEP sweep with 1 queued spike: next cycle all strobes and enables are 0 and spk_valid=0. cmd_ready=1 the following cycle. A new SYN restarts at index 0.
- Back-to-back: TSTEP held valid during a SYN sweep is accepted exactly on the cycle cmd_ready returns to 1. Reserved cmd_type=3 gives a 1-cycle busy pulse with no rd_en.
